// File: rtl/multi_timer.sv
// multi_timer: NUM_CH-channel programmable tick timer on the 8-bit shared bus.
// One prescaler produces a common tick. Each channel has its own period,
// one-shot/periodic mode, status flag and raise/acknowledge interrupt line.
// Reads are registered and returned on the bus in the cycle after the address.
module multi_timer #(
   parameter logic [7:0] BASE_ADDR = 8'hF0,
   parameter int         NUM_CH    = 2,
   parameter int         PRESCALE  = 50000
) (
   input  logic              CLK,
   input  logic              RESET,
   inout  wire  [7:0]        BUS_DATA,
   input  logic [7:0]        BUS_ADDR,
   input  logic              BUS_WE,
   output logic [NUM_CH-1:0] BUS_INTERRUPTS_RAISE,
   input  logic [NUM_CH-1:0] BUS_INTERRUPTS_ACK
);

   localparam int               PW         = $clog2(PRESCALE);
   localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [7:0]       WIN        = 8'(4 * NUM_CH);

   // Time base
   logic [PW-1:0] presc;
   logic          tick;

   // Bus decode
   logic [7:0]    off;
   logic          hit;
   logic [1:0]    sel_ch;
   logic [1:0]    sel_reg;
   logic [7:0]    wdata;

   // Per-channel write strobes and expiry
   logic [NUM_CH-1:0] wr_ctrl;
   logic [NUM_CH-1:0] wr_period;
   logic [NUM_CH-1:0] wr_status;
   logic [NUM_CH-1:0] expire;

   // Channel registers
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] mode;
   logic [NUM_CH-1:0] irq_en;
   logic [NUM_CH-1:0] flag;
   logic [7:0]        period [NUM_CH];
   logic [7:0]        count  [NUM_CH];

   // Read return path
   logic [7:0] rd_mux;
   logic [7:0] rd_data_p1;
   logic       rd_vld_p1;

   assign tick    = (presc == PRESC_LAST);
   assign off     = BUS_ADDR - BASE_ADDR;
   assign hit     = (BUS_ADDR >= BASE_ADDR) && (off < WIN);
   assign sel_ch  = off[3:2];
   assign sel_reg = off[1:0];
   assign wdata   = BUS_DATA;

   // Free-running prescaler; wraps to 0 right after the tick cycle
   always_ff @(posedge CLK) begin
      if (RESET) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Decode bus writes into per-channel register strobes (COUNT is read-only)
   always_comb begin
      wr_ctrl   = '0;
      wr_period = '0;
      wr_status = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (BUS_WE && hit && (sel_ch == 2'(c))) begin
            case (sel_reg)
               2'd0:    wr_ctrl[c]   = 1'b1;
               2'd1:    wr_period[c] = 1'b1;
               2'd3:    wr_status[c] = 1'b1;
               default: ;
            endcase
         end
      end
   end

   // A channel expires on a tick when its count reaches PERIOD-1; PERIOD=0 never expires
   always_comb begin
      expire = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         expire[c] = tick && en[c] && (period[c] != 8'd0) &&
                     (count[c] == (period[c] - 8'd1));
      end
   end

   // Channel state: bus writes override counting; expiry "sets" win over clears
   always_ff @(posedge CLK) begin
      if (RESET) begin
         en     <= '0;
         mode   <= '0;
         irq_en <= '0;
         flag   <= '0;
         BUS_INTERRUPTS_RAISE <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            period[c] <= 8'd0;
            count[c]  <= 8'd0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_ctrl[c]) begin
               en[c]     <= wdata[0];
               mode[c]   <= wdata[1];
               irq_en[c] <= wdata[2];
            end else if (expire[c] && mode[c]) begin
               en[c] <= 1'b0;
            end

            if (wr_period[c]) begin
               period[c] <= wdata;
               count[c]  <= 8'd0;
            end else if (wr_ctrl[c] && wdata[0] && !en[c]) begin
               count[c] <= 8'd0;
            end else if (tick && en[c]) begin
               count[c] <= expire[c] ? 8'd0 : count[c] + 8'd1;
            end

            if (expire[c]) begin
               flag[c] <= 1'b1;
            end else if (wr_status[c] && wdata[0]) begin
               flag[c] <= 1'b0;
            end

            if (expire[c] && irq_en[c]) begin
               BUS_INTERRUPTS_RAISE[c] <= 1'b1;
            end else if (BUS_INTERRUPTS_ACK[c]) begin
               BUS_INTERRUPTS_RAISE[c] <= 1'b0;
            end
         end
      end
   end

   // Select the addressed register for a read
   always_comb begin
      rd_mux = 8'd0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (sel_ch == 2'(c)) begin
            case (sel_reg)
               2'd0:    rd_mux = {5'b0, irq_en[c], mode[c], en[c]};
               2'd1:    rd_mux = period[c];
               2'd2:    rd_mux = count[c];
               default: rd_mux = {7'b0, flag[c]};
            endcase
         end
      end
   end

   // ---- stage p1: registered read data, driven for exactly one cycle ----
   // Read-enable: marks the cycle in which this block owns the bus
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rd_vld_p1 <= 1'b0;
      end else begin
         rd_vld_p1 <= !BUS_WE && hit;
      end
   end

   // Read data capture (data path, not reset)
   always_ff @(posedge CLK) begin
      if (!BUS_WE && hit) begin
         rd_data_p1 <= rd_mux;
      end
   end

   assign BUS_DATA = rd_vld_p1 ? rd_data_p1 : 8'hZZ;

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed scenarios plus randomized bus traffic, every cycle
// checked against a register-file level model of the timer peripheral.
module tb_multi_timer;

   localparam int P = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic       we;
   logic [1:0] ack;
   logic [1:0] raise;
   wire  [7:0] bus;

   typedef struct packed {
      logic [31:0]     cyc;
      logic [1:0][7:0] ctrl;
      logic [1:0][7:0] period;
      logic [1:0][7:0] count;
      logic [1:0]      flag;
      logic [1:0]      raise;
      logic            rd_vld;
      logic [7:0]      rd_val;
   } mstate_t;

   mstate_t m = '0;
   int      vectors = 0;
   int      miscompares = 0;
   bit      checking = 1'b0;
   int      cyc_cnt = 0;

   always #5 clk = ~clk;

   // Bench is bus master except in the cycle the peripheral returns read data
   assign bus = m.rd_vld ? 8'hzz : (we ? wdata : 8'h00);

   multi_timer #(.BASE_ADDR(8'hF0), .NUM_CH(2), .PRESCALE(P)) dut (
      .CLK(clk),
      .RESET(rst),
      .BUS_DATA(bus),
      .BUS_ADDR(addr),
      .BUS_WE(we),
      .BUS_INTERRUPTS_RAISE(raise),
      .BUS_INTERRUPTS_ACK(ack)
   );

   // Register-file model: one call = what one clock edge does to the peripheral
   function automatic mstate_t model_step(mstate_t s, logic r, logic [7:0] a,
                                          logic w, logic [7:0] d, logic [1:0] k);
      mstate_t n;
      logic    tk, hit, fire;
      int      off, ch, rg;
      if (r) return '0;
      n = s;
      tk = (s.cyc % P) == (P - 1);
      n.cyc = tk ? 32'd0 : s.cyc + 32'd1;
      hit = (a >= 8'hF0) && (a <= 8'hF7);
      off = int'(a) - 240;
      ch = off / 4;
      rg = off % 4;
      n.rd_vld = hit && !w;
      if (n.rd_vld) begin
         case (rg)
            0:       n.rd_val = s.ctrl[ch];
            1:       n.rd_val = s.period[ch];
            2:       n.rd_val = s.count[ch];
            default: n.rd_val = {7'b0, s.flag[ch]};
         endcase
      end
      for (int c = 0; c < 2; c++) begin
         fire = tk && s.ctrl[c][0] && (s.period[c] != 0) && (s.count[c] == s.period[c] - 8'd1);
         if (tk && s.ctrl[c][0]) n.count[c] = fire ? 8'd0 : 8'(s.count[c] + 8'd1);
         if (fire && s.ctrl[c][1]) n.ctrl[c][0] = 1'b0;
         if (w && hit && ch == c && rg == 0) begin
            if (d[0] && !s.ctrl[c][0]) n.count[c] = 8'd0;
            n.ctrl[c] = d & 8'h07;
         end
         if (w && hit && ch == c && rg == 1) begin
            n.period[c] = d;
            n.count[c]  = 8'd0;
         end
         if (w && hit && ch == c && rg == 3 && d[0]) n.flag[c] = 1'b0;
         if (fire) n.flag[c] = 1'b1;
         if (k[c]) n.raise[c] = 1'b0;
         if (fire && s.ctrl[c][2]) n.raise[c] = 1'b1;
      end
      return n;
   endfunction

   always @(posedge clk) m <= model_step(m, rst, addr, we, wdata, ack);
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Per-cycle compare of interrupt lines and bus contents against the model
   always @(negedge clk) begin
      if (checking) begin
         vectors++;
         if (raise !== m.raise) begin
            miscompares++;
            $display("FAIL raise: dut=%b model=%b at %0t", raise, m.raise, $time);
         end
         vectors++;
         if (m.rd_vld) begin
            if (bus !== m.rd_val) begin
               miscompares++;
               $display("FAIL rdata: dut=%h model=%h at %0t", bus, m.rd_val, $time);
            end
         end else if (bus !== (we ? wdata : 8'h00)) begin
            miscompares++;
            $display("FAIL bus_drive: bus=%h bench_drive=%h at %0t", bus,
                     (we ? wdata : 8'h00), $time);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      addr  = 8'h00;
      we    = 1'b0;
      wdata = 8'h00;
   endtask

   task automatic idle(int n);
      set_idle();
      repeat (n) step();
   endtask

   task automatic wr(logic [7:0] a, logic [7:0] d);
      addr  = a;
      we    = 1'b1;
      wdata = d;
      step();
      set_idle();
   endtask

   task automatic rd(logic [7:0] a, output logic [7:0] v);
      addr  = a;
      we    = 1'b0;
      wdata = 8'h00;
      step();
      set_idle();
      @(negedge clk);
      v = bus;
      step();
   endtask

   task automatic wait_raise(int ch, int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (raise[ch]) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic ack_pulse(logic [1:0] k);
      ack = k;
      step();
      ack = 2'b00;
   endtask

   initial begin
      logic [7:0] v, a, d, prev;
      bit         ok, seen, saw255, wrapped;
      int         r0, r1, r2, op;

      rst = 1'b1;
      ack = 2'b00;
      set_idle();
      step();
      checking = 1'b1;
      step();
      rst = 1'b0;

      // Reset state
      check("reset_raise", raise, 0);
      for (int i = 0; i < 8; i++) begin
         rd(8'(8'hF0 + i), v);
         check($sformatf("reset_rd_%0h", 8'hF0 + i), v, 0);
      end

      // Periodic channel 0, period 3 ticks
      wr(8'hF1, 8'd3);
      wr(8'hF0, 8'h05);
      wait_raise(0, 16, ok);
      check("per_first_rise", ok, 1);
      r0 = cyc_cnt;
      ack_pulse(2'b01);
      check("per_ack_drop", raise[0], 0);
      wait_raise(0, 16, ok);
      check("per_interval1", cyc_cnt - r0, 12);
      r1 = cyc_cnt;
      ack_pulse(2'b01);
      rd(8'hF3, v);
      check("per_status_set", v, 8'h01);
      wr(8'hF3, 8'h01);
      rd(8'hF3, v);
      check("per_status_clr", v, 8'h00);
      wait_raise(0, 16, ok);
      check("per_interval2", cyc_cnt - r1, 12);
      r2 = cyc_cnt;

      // Collision: ACK and STATUS clear in the expire cycle
      ack_pulse(2'b01);
      wr(8'hF3, 8'h01);
      for (int i = 0; i < 16 && cyc_cnt < r2 + 11; i++) step();
      ack   = 2'b01;
      addr  = 8'hF3;
      we    = 1'b1;
      wdata = 8'h01;
      step();
      set_idle();
      ack = 2'b00;
      check("col_raise", raise[0], 1);
      rd(8'hF3, v);
      check("col_flag", v, 8'h01);
      wr(8'hF0, 8'h00);
      ack_pulse(2'b01);
      wr(8'hF3, 8'h01);

      // One-shot channel 1
      wr(8'hF5, 8'd2);
      wr(8'hF4, 8'h07);
      wait_raise(1, 12, ok);
      check("os_rise", ok, 1);
      ack_pulse(2'b10);
      rd(8'hF4, v);
      check("os_ctrl", v, 8'h06);
      rd(8'hF6, v);
      check("os_count", v, 8'h00);
      seen = 1'b0;
      repeat (80) begin
         step();
         if (raise[1]) seen = 1'b1;
      end
      check("os_no_second", seen, 0);
      rd(8'hF6, v);
      check("os_count_hold", v, 8'h00);

      // PERIOD=0: free wrap, never expires
      wr(8'hF1, 8'd0);
      wr(8'hF0, 8'h05);
      prev = 8'd0;
      saw255 = 1'b0;
      wrapped = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 600; i++) begin
         rd(8'hF2, v);
         if (v == 8'd255) saw255 = 1'b1;
         if (v < prev) wrapped = 1'b1;
         prev = v;
         if (raise[0]) seen = 1'b1;
      end
      check("p0_saw255", saw255, 1);
      check("p0_wrapped", wrapped, 1);
      check("p0_no_raise", seen, 0);
      rd(8'hF3, v);
      check("p0_no_flag", v, 8'h00);

      // Both channels period 1, enabled right after a tick
      wr(8'hF0, 8'h00);
      wr(8'hF4, 8'h00);
      wr(8'hF1, 8'd1);
      wr(8'hF5, 8'd1);
      for (int i = 0; i < 4 && (m.cyc % P) != 0; i++) step();
      wr(8'hF0, 8'h05);
      wr(8'hF4, 8'h05);
      for (int i = 0; i < 8 && raise == 2'b00; i++) step();
      check("both_same_edge", raise, 2'b11);

      // Reset mid-handshake
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_raise", raise, 0);
      for (int i = 0; i < 8; i++) begin
         rd(8'(8'hF0 + i), v);
         check($sformatf("rst_rd_%0h", 8'hF0 + i), v, 0);
      end
      idle(20);
      check("rst_raise_hold", raise, 0);
      rd(8'hF2, v);
      check("rst_count0_hold", v, 0);
      rd(8'hF6, v);
      check("rst_count1_hold", v, 0);

      // Randomized traffic, including out-of-window addresses and resets
      for (int i = 0; i < 2500; i++) begin
         op  = int'($urandom_range(0, 99));
         ack = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
         a   = 8'h E8 + 8'($urandom_range(0, 23));
         if (op < 2) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
         end else if (op < 40) begin
            idle(1);
         end else if (op < 70) begin
            rd(a, v);
         end else begin
            d = 8'($urandom);
            if (a[1:0] == 2'd1) d = 8'($urandom_range(0, 4));
            wr(a, d);
         end
      end
      ack = 2'b00;
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
